fp_mul_booth_seq: RTL and testbench

//  Multi-cycle radix-4 Booth multiplier for the single-precision FPU multiply path.

---
 rtl/fp_mul_booth_seq.sv | 174 +++++++++++++++++
 tb/tb_fp_mul_booth_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_booth_seq.sv
// Multi-cycle radix-4 Booth multiplier for the single-precision multiply path.
// Forms the unsigned significand product {hidX,frc_X} * {hidY,frc_Y}.
// One Booth digit is retired per RUN cycle. A FIN cycle then registers the
// result, and DONE holds it until the normalisation stage takes it.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE. out_valid is high only in DONE,
// and frc_Z_full/norm_n stay stable while out_valid is high and out_ready is low.
module fp_mul_booth_seq #(
    parameter int MANT_W = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [MANT_W-2:0]     frc_X,
    input  logic [MANT_W-2:0]     frc_Y,
    input  logic                  Xsub,
    input  logic                  Ysub,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*MANT_W-1:0]   frc_Z_full,
    output logic                  norm_n,
    output logic                  busy,
    output logic [1:0]            state_dbg
);

    // Signed accumulator with sign and overflow guard bits above the product.
    localparam int ACC_W = 2*MANT_W + 3;
    // Multiplier register: two zero-extension bits on top, Booth pad bit at the bottom.
    localparam int B_W   = MANT_W + 3;
    // Index of the last Booth digit. The digit count is LAST+1.
    localparam int LAST  = MANT_W / 2;
    localparam int CNT_W = $clog2(LAST + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [MANT_W-1:0]  a_reg;
    logic [B_W-1:0]     b_reg;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               last_digit;

    // Booth recoding signals for the current digit.
    logic [CNT_W:0]     dig_pos;
    logic [2:0]         digit;
    logic [ACC_W-1:0]   a_ext;
    logic [ACC_W-1:0]   pp_mult;
    logic [ACC_W-1:0]   pp;

    // In IDLE, flush wins over in_valid, so no operation is accepted that cycle.
    assign accept     = (state == S_IDLE) && in_valid && !flush;
    assign last_digit = (cnt == CNT_W'(LAST));

    assign in_ready   = (state == S_IDLE);
    assign out_valid  = (state == S_DONE);
    assign busy       = (state != S_IDLE);
    assign norm_n     = frc_Z_full[2*MANT_W-1];
    assign state_dbg  = state;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic. Flush aborts from any busy state.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_n = S_IDLE;
                end else if (last_digit) begin
                    state_n = S_FIN;
                end
            end
            S_FIN: begin
                if (flush) begin
                    state_n = S_IDLE;
                end else begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                if (flush || out_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Booth recoding of digit cnt. The result is a signed multiple of A at weight 4^cnt.
    always_comb begin
        dig_pos = {cnt, 1'b0};
        digit   = b_reg[dig_pos +: 3];
        a_ext   = {{(ACC_W-MANT_W){1'b0}}, a_reg};
        pp_mult = '0;
        case (digit)
            3'b001, 3'b010: pp_mult = a_ext;
            3'b011:         pp_mult = a_ext << 1;
            3'b100:         pp_mult = '0 - (a_ext << 1);
            3'b101, 3'b110: pp_mult = '0 - a_ext;
            default:        pp_mult = '0;
        endcase
        pp = pp_mult << dig_pos;
    end

    // Datapath: latch operands on accept, accumulate in RUN, register the product in FIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg      <= '0;
            b_reg      <= '0;
            acc        <= '0;
            cnt        <= '0;
            frc_Z_full <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        a_reg <= {!Xsub, frc_X};
                        b_reg <= {2'b00, !Ysub, frc_Y, 1'b0};
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        cnt        <= '0;
                        frc_Z_full <= '0;
                    end else begin
                        acc <= acc + pp;
                        if (!last_digit) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    // The guard bits above the product are zero for unsigned operands.
                    if (flush) begin
                        frc_Z_full <= '0;
                    end else begin
                        frc_Z_full <= acc[2*MANT_W-1:0];
                    end
                end
                S_DONE: begin
                    if (flush) begin
                        frc_Z_full <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_booth_seq.sv
// Testbench for fp_mul_booth_seq: scoreboard against a plain-multiply reference.
module tb_fp_mul_booth_seq;

    localparam int W = 48;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [22:0]   frc_X = '0;
    logic [22:0]   frc_Y = '0;
    logic          Xsub = 1'b0;
    logic          Ysub = 1'b0;
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  frc_Z_full;
    logic          norm_n;
    logic          busy;
    logic [1:0]    state_dbg;

    fp_mul_booth_seq #(.MANT_W(24)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .frc_X      (frc_X),
        .frc_Y      (frc_Y),
        .Xsub       (Xsub),
        .Ysub       (Ysub),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frc_Z_full (frc_Z_full),
        .norm_n     (norm_n),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];
    int           lat_q[$];
    bit bp_en = 1'b0;
    bit force_low = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s", name);
    endtask

    // Reference: the product of the two 24-bit significands.
    function automatic logic [W-1:0] ref_mul(input logic [22:0] x, input logic [22:0] y,
                                             input logic xs, input logic ys);
        logic [W-1:0] sx;
        logic [W-1:0] sy;
        sx = W'({!xs, x});
        sy = W'({!ys, y});
        return sx * sy;
    endfunction

    // Downstream readiness: forced low, randomly throttled, or always ready.
    always @(posedge clk) begin
        #1;
        if (force_low)  out_ready = 1'b0;
        else if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
        else            out_ready = 1'b1;
    end

    // Driver. It is called just after a rising edge and returns just after the accept edge.
    task automatic issue(input logic [22:0] x, input logic [22:0] y,
                         input logic xs, input logic ys, input bit push);
        int t;
        t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            fail_now("issue_timeout");
        end else begin
            in_valid = 1'b1;
            frc_X = x; frc_Y = y; Xsub = xs; Ysub = ys;
            if (push) exp_q.push_back(ref_mul(x, y, xs, ys));
            @(posedge clk); #1;
            if (push) lat_q.push_back(cyc);
            // Garbage operands with in_valid still high must not be resampled.
            frc_X = 23'($urandom); frc_Y = 23'($urandom);
            Xsub = 1'($urandom); Ysub = 1'($urandom);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
    endtask

    // Monitor: latency, hold stability, and results popped from the scoreboard.
    bit           seen = 1'b0;
    bit           holding = 1'b0;
    bit           exp_idle = 1'b0;
    logic [W-1:0] hold_val = '0;
    logic [W-1:0] e;

    always @(negedge clk) begin
        if (!rst) begin
            if (holding) begin
                check("hold_out_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'(frc_Z_full), 64'(hold_val));
                check("hold_in_ready", 64'(in_ready), 64'd0);
            end
            if (exp_idle) begin
                check("post_hs_in_ready", 64'(in_ready), 64'd1);
                check("post_hs_out_valid", 64'(out_valid), 64'd0);
                exp_idle = 1'b0;
            end
            if (out_valid && !seen) begin
                seen = 1'b1;
                if (lat_q.size() == 0) fail_now("latency_unexpected_output");
                else check("latency", 64'(cyc - lat_q.pop_front()), 64'd14);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_output");
                end else begin
                    e = exp_q.pop_front();
                    check("product", 64'(frc_Z_full), 64'(e));
                    check("norm_n", 64'(norm_n), 64'(e[W-1]));
                end
                seen = 1'b0;
                exp_idle = 1'b1;
            end
            holding  = out_valid && !out_ready;
            hold_val = frc_Z_full;
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_frc_Z_full"}, 64'(frc_Z_full), 64'd0);
        check({tag, "_norm_n"}, 64'(norm_n), 64'd0);
    endtask

    // Main sequence.
    initial begin
        int t;
        logic [22:0] rx;
        logic [22:0] ry;
        logic        rxs;
        logic        rys;

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed products, including both corners and subnormal operands.
        issue(23'h000000, 23'h000000, 1'b0, 1'b0, 1'b1);
        issue(23'h7FFFFF, 23'h7FFFFF, 1'b0, 1'b0, 1'b1);
        issue(23'h2DF854, 23'h490FDB, 1'b0, 1'b0, 1'b1);
        issue(23'h2DF854, 23'h490FDB, 1'b1, 1'b0, 1'b1);
        issue(23'h2DF854, 23'h490FDB, 1'b1, 1'b1, 1'b1);
        issue(23'h000000, 23'h490FDB, 1'b1, 1'b0, 1'b1);
        drain();
        check("case1_const", 64'(ref_mul(23'h0, 23'h0, 1'b0, 1'b0)), 64'h4000_0000_0000);

        // Backpressure in DONE, then back-to-back operations.
        force_low = 1'b1;
        issue(23'h123456, 23'h654321, 1'b0, 1'b0, 1'b1);
        t = 0;
        while (!out_valid && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!out_valid) fail_now("wait_out_valid_timeout");
        repeat (5) @(posedge clk);
        #1;
        force_low = 1'b0;
        issue(23'h7FFFFF, 23'h000001, 1'b0, 1'b0, 1'b1);
        issue(23'h400000, 23'h400000, 1'b0, 1'b1, 1'b1);
        drain();

        // Asynchronous reset during RUN at digit 6.
        issue(23'h7FFFFF, 23'h7FFFFF, 1'b0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("pre_rst_busy", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check_idle_outputs("mid_rst");
        rst = 1'b0;
        @(posedge clk); #1;

        // Leave a nonzero result in the output register so the flush clear is visible.
        issue(23'h7FFFFF, 23'h7FFFFF, 1'b0, 1'b0, 1'b1);
        drain();
        issue(23'h7FFFFF, 23'h7FFFFF, 1'b0, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_idle_outputs("flush");

        // In IDLE, flush blocks an accept.
        flush = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_idle_busy", 64'(busy), 64'd0);
        issue(23'h7FFFFF, 23'h7FFFFF, 1'b0, 1'b0, 1'b1);
        drain();

        // Random operands with random backpressure.
        bp_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rx  = ($urandom_range(0, 7) == 0) ? 23'h0 : 23'($urandom);
            ry  = ($urandom_range(0, 7) == 0) ? 23'h7FFFFF : 23'($urandom);
            rxs = ($urandom_range(0, 5) == 0);
            rys = ($urandom_range(0, 5) == 0);
            issue(rx, ry, rxs, rys, 1'b1);
        end
        drain();
        bp_en = 1'b0;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
